// File: rtl/mem_stage_if.sv
// Bundle of the Execute-side inputs, data-memory handshake and writeback
// outputs of the memory-access stage. The stage itself uses the slave view.
interface mem_stage_if;
  // Execute stage
  logic        ex_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] alu_out;
  logic [3:0]  reg_dest_in;
  logic        mem_wr_in;
  logic        wb_sel_in;
  logic        reg_wr_in;
  logic        stall;
  // Data memory
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  // Writeback
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [3:0]  wb_reg_dest;
  logic        wb_reg_wr;
  logic        err;

  modport slave (
    input  ex_valid, mem_addr, mem_data, alu_out, reg_dest_in,
           mem_wr_in, wb_sel_in, reg_wr_in, dm_rdata, dm_ack,
    output stall, dm_req, dm_we, dm_addr, dm_wdata,
           wb_valid, wb_data, wb_reg_dest, wb_reg_wr, err
  );

  modport master (
    output ex_valid, mem_addr, mem_data, alu_out, reg_dest_in,
           mem_wr_in, wb_sel_in, reg_wr_in, dm_rdata, dm_ack,
    input  stall, dm_req, dm_we, dm_addr, dm_wdata,
           wb_valid, wb_data, wb_reg_dest, wb_reg_wr, err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results straight to writeback, and runs a
// req/ack transaction with data memory for loads and stores, stalling
// upstream while the access is outstanding. A bounded wait (TIMEOUT) squashes
// a hung access and raises a sticky error flag.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               dm_req_q, dm_req_d;
  logic               dm_we_q, dm_we_d;
  logic [31:0]        dm_addr_q, dm_addr_d;
  logic [31:0]        dm_wdata_q, dm_wdata_d;
  logic               wb_valid_q, wb_valid_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [3:0]         wb_reg_dest_q, wb_reg_dest_d;
  logic               wb_reg_wr_q, wb_reg_wr_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Instruction context held across the memory access
  logic [3:0]         lat_dest_q, lat_dest_d;
  logic               lat_reg_wr_q, lat_reg_wr_d;
  logic               lat_load_q, lat_load_d;

  logic               is_mem;
  logic [CNT_W:0]     cnt_inc;
  logic               timeout_hit;

  // A store with the load-select bit also set is still a store.
  assign is_mem      = bus.mem_wr_in | bus.wb_sel_in;
  // The wait count after this BUSY cycle; reaching TIMEOUT ends the access.
  assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  assign bus.stall       = (state_q == BUSY);
  assign bus.dm_req      = dm_req_q;
  assign bus.dm_we       = dm_we_q;
  assign bus.dm_addr     = dm_addr_q;
  assign bus.dm_wdata    = dm_wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_reg_dest = wb_reg_dest_q;
  assign bus.wb_reg_wr   = wb_reg_wr_q;
  assign bus.err         = err_q;

  // Next-state and registered-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d       = state_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_reg_dest_d = wb_reg_dest_q;
    wb_reg_wr_d   = 1'b0;
    err_d         = err_q;
    cnt_d         = cnt_q;
    lat_dest_d    = lat_dest_q;
    lat_reg_wr_d  = lat_reg_wr_q;
    lat_load_d    = lat_load_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!is_mem) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = bus.alu_out;
            wb_reg_dest_d = bus.reg_dest_in;
            wb_reg_wr_d   = bus.reg_wr_in;
          end else begin
            dm_req_d     = 1'b1;
            dm_we_d      = bus.mem_wr_in;
            dm_addr_d    = bus.mem_addr;
            dm_wdata_d   = bus.mem_data;
            lat_dest_d   = bus.reg_dest_in;
            lat_load_d   = ~bus.mem_wr_in;
            lat_reg_wr_d = bus.reg_wr_in & ~bus.mem_wr_in;
            cnt_d        = '0;
            state_d      = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.dm_ack) begin
          // Completion takes priority over a timeout on the same edge.
          dm_req_d      = 1'b0;
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_reg_dest_d = lat_dest_q;
          if (lat_load_q) begin
            wb_data_d   = bus.dm_rdata;
            wb_reg_wr_d = lat_reg_wr_q;
          end
        end else if (timeout_hit) begin
          // Retire the hung instruction as a squashed bubble.
          dm_req_d      = 1'b0;
          err_d         = 1'b1;
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_reg_dest_d = lat_dest_q;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any outstanding access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_reg_dest_q <= '0;
      wb_reg_wr_q   <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      lat_dest_q    <= '0;
      lat_reg_wr_q  <= 1'b0;
      lat_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_reg_dest_q <= wb_reg_dest_d;
      wb_reg_wr_q   <= wb_reg_wr_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      lat_dest_q    <= lat_dest_d;
      lat_reg_wr_q  <= lat_reg_wr_d;
      lat_load_q    <= lat_load_d;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage CPU pipeline, sitting between the Execute stage and writeback. It takes the Execute stage's address, store data, ALU result and control bits, and runs a req/ack handshake with the data memory. While an access is outstanding it stalls upstream stages, then presents a registered writeback bundle: a load result, the ALU result, or a store retire.

## Interface
Parameters:
- TIMEOUT, 255, maximum BUSY cycles waiting for dm_ack; 0 disables the timeout.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  Execute stage presents a valid instruction
- mem_addr  in  32  data memory address (ALU result or stack pointer)
- mem_data  in  32  store data
- alu_out  in  32  ALU result for non-load writeback
- reg_dest_in  in  4  destination register
- mem_wr_in  in  1  instruction is a store
- wb_sel_in  in  1  1 = load (writeback from memory), 0 = writeback from alu_out
- reg_wr_in  in  1  instruction writes the register file
- stall  out  1  upstream must hold ex_* stable; block ignores ex_* while high
- dm_req  out  1  data memory request
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  32  memory address
- dm_wdata  out  32  memory write data
- dm_rdata  in  32  memory read data, valid in the dm_ack cycle
- dm_ack  in  1  memory completion, one-cycle pulse
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  32  writeback data
- wb_reg_dest  out  4  writeback destination
- wb_reg_wr  out  1  register-file write enable (qualified by wb_valid)
- err  out  1  sticky memory timeout flag

## Operation
- FSM has two states: IDLE and BUSY. stall = (state == BUSY), driven combinationally from the state register.
- IDLE, ex_valid=0: next edge drives wb_valid=0 and wb_reg_wr=0 (bubble). wb_data and wb_reg_dest hold.
- IDLE, ex_valid=1, non-memory (mem_wr_in=0, wb_sel_in=0): next edge drives wb_valid=1, wb_data=alu_out, wb_reg_dest=reg_dest_in, wb_reg_wr=reg_wr_in. State stays IDLE.
- IDLE, ex_valid=1, memory op (mem_wr_in or wb_sel_in):
  - next edge registers dm_req=1, dm_we=mem_wr_in, dm_addr=mem_addr, dm_wdata=mem_data.
  - reg_dest_in, reg_wr_in and the op type are latched internally.
  - wb_valid=0; state -> BUSY.
- mem_wr_in=1 with wb_sel_in=1 is treated as a store; wb_reg_wr is forced to 0.
- BUSY: dm_req, dm_we, dm_addr and dm_wdata hold until dm_ack is sampled high. On that edge:
  - dm_req -> 0; state -> IDLE; wb_valid=1.
  - load: wb_data=dm_rdata, wb_reg_wr=latched reg_wr.
  - store: wb_reg_wr=0; wb_data holds.
- Timeout counter:
  - cleared on entry to BUSY, increments each BUSY cycle without ack.
  - if TIMEOUT != 0 and the count reaches TIMEOUT: dm_req -> 0, err -> 1 (sticky until reset), instruction retired squashed (wb_valid=1, wb_reg_wr=0), state -> IDLE.
  - dm_ack on the same edge as the timeout wins; the access completes normally.
- dm_ack while IDLE is ignored.
- Reset values: state IDLE; dm_req, dm_we, wb_valid, wb_reg_wr, err = 0; dm_addr, dm_wdata, wb_data = 0; wb_reg_dest = 0; counter 0. stall=0 follows from state.
- Reset asserted mid-BUSY aborts immediately and asynchronously: dm_req drops, nothing is retired.

## Timing
- Non-memory instruction: 1-cycle latency, ex -> wb outputs on the next edge; no stall.
- Memory instruction accepted at edge E0: dm_req high from E0.
  - If dm_ack is sampled at edge E0+k (k>=1), wb outputs are valid after E0+k.
  - stall is high for cycles E0..E0+k-1 (k cycles).
  - Minimum case (memory acks in its first request cycle): k=1, 2-cycle latency, 1 stall cycle.
- Back-to-back loads with 1-cycle memory: one instruction retires every 2 cycles.
- Timeout: with TIMEOUT=N and no ack, dm_req is high for exactly N cycles; err rises on the same edge dm_req falls.
- All outputs except stall are registered.

## Test plan
- ALU passthrough: ex_valid=1, alu_out=0x1234, reg_dest_in=5, reg_wr_in=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_reg_dest=5, wb_reg_wr=1, stall never high.
- Load, ack after 3 cycles: wb_sel_in=1, mem_addr=0x40, reg_dest_in=3, dm_rdata=0xDEADBEEF -> dm_req/dm_we=0/dm_addr=0x40 held 3 cycles, stall high 3 cycles, then wb_valid=1, wb_data=0xDEADBEEF, wb_reg_wr=1.
- Store, immediate ack: mem_wr_in=1, mem_addr=0x10, mem_data=0xA5A5A5A5 -> dm_req 1 cycle with dm_we=1, dm_wdata=0xA5A5A5A5; wb_valid=1 with wb_reg_wr=0; wb_data unchanged.
- Timeout: TIMEOUT=4, load, never ack -> dm_req high exactly 4 cycles, err=1 and stays 1, squashed retire (wb_valid=1, wb_reg_wr=0), next ALU instruction retires normally.
- Stray ack and conflicting bits: dm_ack pulsed in IDLE -> no output change; mem_wr_in=1 and wb_sel_in=1 -> write access, wb_reg_wr=0.
- Reset mid-BUSY: assert rst_n=0 two cycles into a load -> dm_req, stall, wb_valid, err all 0 immediately; after release a new load completes normally.
